// File: rtl/mod_game_ctrl.sv
// Modulus game controller: problem sequencing, iterative remainder
// computation, answer judging, health drain, score, streak and level.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start
// GEN    | latch a new dividend/divisor from the RNG sources (1 cycle)
// CALC   | subtract divisor from remainder, one step per cycle
// WAIT   | problem shown, waiting for a keypad answer
// OVER   | health exhausted, outputs frozen until start
module mod_game_ctrl #(
  parameter int DIVIDEND_W  = 7,
  parameter int ANS_W       = 4,
  parameter int DIVISOR_MAX = 9,
  parameter int HEALTH_W    = 7,
  parameter int INIT_HEALTH = 60,
  parameter int MAX_HEALTH  = 99,
  parameter int GAIN        = 5,
  parameter int PENALTY     = 3,
  parameter int RATE_W      = 27,
  parameter int BASE_RATE   = 36000000,
  parameter int RATE_STEP   = 4000000,
  parameter int MIN_RATE    = 6000000,
  parameter int STREAK_LEN  = 5,
  parameter int MAX_LEVEL   = 7,
  parameter int SCORE_MAX   = 999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] rng_dividend,
  input  logic [3:0]            rng_divisor,
  input  logic [ANS_W-1:0]      answer,
  input  logic                  answer_valid,
  output logic [DIVIDEND_W-1:0] dividend,
  output logic [3:0]            divisor,
  output logic [HEALTH_W-1:0]   health,
  output logic [2:0]            level,
  output logic [9:0]            score,
  output logic                  problem_ready,
  output logic                  game_over,
  output logic [2:0]            state
);

  localparam int STRK_W = (STREAK_LEN < 2) ? 1 : $clog2(STREAK_LEN + 1);
  localparam int CMP_W  = (ANS_W > DIVIDEND_W) ? ANS_W : DIVIDEND_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GEN  = 3'd1,
    S_CALC = 3'd2,
    S_WAIT = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] remainder, remainder_d, dividend_d;
  logic [3:0]            divisor_d, div_mapped;
  logic [HEALTH_W-1:0]   health_d, h_adj;
  logic [HEALTH_W:0]     h_sum;
  logic [2:0]            level_d;
  logic [9:0]            score_d;
  logic [STRK_W-1:0]     streak, streak_d;
  logic [RATE_W-1:0]     tick, tick_d, rate;
  logic                  active, drain_hit, is_correct, is_wrong;

  // Drain period for a level, floored at MIN_RATE; computed wide so a
  // large level*RATE_STEP cannot wrap below the floor.
  function automatic logic [RATE_W-1:0] rate_of(input logic [2:0] lv);
    longint r;
    r = longint'(BASE_RATE) - longint'(lv) * longint'(RATE_STEP);
    if (r < longint'(MIN_RATE)) r = longint'(MIN_RATE);
    return r[RATE_W-1:0];
  endfunction

  assign state         = state_q;
  assign problem_ready = (state_q == S_WAIT);
  assign game_over     = (state_q == S_OVER);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath next values; answer adjustment is applied
  // before the drain decrement, each step saturating on its own.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend;
    divisor_d   = divisor;
    remainder_d = remainder;
    level_d     = level;
    score_d     = score;
    streak_d    = streak;
    tick_d      = tick;

    rate       = rate_of(level);
    active     = (state_q == S_GEN) || (state_q == S_CALC) || (state_q == S_WAIT);
    drain_hit  = active && (tick >= rate - RATE_W'(1));
    is_correct = (state_q == S_WAIT) && answer_valid &&
                 (CMP_W'(answer) == CMP_W'(remainder));
    is_wrong   = (state_q == S_WAIT) && answer_valid &&
                 (CMP_W'(answer) != CMP_W'(remainder));

    if (rng_divisor < 4'd2)                  div_mapped = 4'(DIVISOR_MAX) - rng_divisor;
    else if (rng_divisor > 4'(DIVISOR_MAX))  div_mapped = 4'(DIVISOR_MAX);
    else                                     div_mapped = rng_divisor;

    h_sum = {1'b0, health} + (HEALTH_W+1)'(GAIN);
    h_adj = health;
    if (is_correct)
      h_adj = (h_sum > (HEALTH_W+1)'(MAX_HEALTH)) ? HEALTH_W'(MAX_HEALTH) : h_sum[HEALTH_W-1:0];
    else if (is_wrong)
      h_adj = (health < HEALTH_W'(PENALTY)) ? '0 : health - HEALTH_W'(PENALTY);
    health_d = (drain_hit && (h_adj != '0)) ? h_adj - HEALTH_W'(1) : h_adj;

    if (active) tick_d = drain_hit ? '0 : tick + RATE_W'(1);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d  = S_GEN;
          health_d = HEALTH_W'(INIT_HEALTH);
          level_d  = '0;
          score_d  = '0;
          streak_d = '0;
          tick_d   = '0;
        end
      end
      S_GEN: begin
        dividend_d  = rng_dividend;
        remainder_d = rng_dividend;
        divisor_d   = div_mapped;
        state_d     = S_CALC;
      end
      S_CALC: begin
        if (remainder >= DIVIDEND_W'(divisor)) remainder_d = remainder - DIVIDEND_W'(divisor);
        else                                   state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (is_correct) begin
          state_d = S_GEN;
          score_d = (score >= 10'(SCORE_MAX)) ? score : score + 10'd1;
          if (streak >= STRK_W'(STREAK_LEN - 1)) begin
            streak_d = '0;
            level_d  = (level >= 3'(MAX_LEVEL)) ? level : level + 3'd1;
          end else begin
            streak_d = streak + STRK_W'(1);
          end
        end else if (is_wrong) begin
          streak_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Running out of health wins over any other transition.
    if (active && (health_d == '0)) state_d = S_OVER;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend  <= '0;
      divisor   <= '0;
      remainder <= '0;
      health    <= HEALTH_W'(INIT_HEALTH);
      level     <= '0;
      score     <= '0;
      streak    <= '0;
      tick      <= '0;
    end else begin
      dividend  <= dividend_d;
      divisor   <= divisor_d;
      remainder <= remainder_d;
      health    <= health_d;
      level     <= level_d;
      score     <= score_d;
      streak    <= streak_d;
      tick      <= tick_d;
    end
  end

endmodule
